// File: rtl/fetch_unit_pkg.sv
// Shared widths, instruction decode patterns (common with dispatch) and the fetch state type.
// Conditional-branch prediction policy is selected by FETCH_BTFN_PREDICT_EN in fetch_unit.
`ifndef INSNBITS_SIZE
`define INSNBITS_SIZE 32
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

package fetch_unit_pkg;

  localparam int INSN_W = `INSNBITS_SIZE;
  localparam int GPR_W  = `GPR_SIZE;

  // Mask/pattern pairs: a word is of a class when (word & MASK) == PAT.
  localparam logic [31:0] B_MASK     = 32'hFC00_0000;
  localparam logic [31:0] B_PAT      = 32'h1400_0000;
  localparam logic [31:0] BL_PAT     = 32'h9400_0000;
  localparam logic [31:0] BCOND_MASK = 32'hFF00_0010;
  localparam logic [31:0] BCOND_PAT  = 32'h5400_0000;
  localparam logic [31:0] CB_MASK    = 32'h7F00_0000;
  localparam logic [31:0] CBZ_PAT    = 32'h3400_0000;
  localparam logic [31:0] CBNZ_PAT   = 32'h3500_0000;
  localparam logic [31:0] HLT_MASK   = 32'hFFE0_001F;
  localparam logic [31:0] HLT_PAT    = 32'hD440_0000;

  typedef enum logic [0:0] {
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_t;

  function automatic logic insn_matches(input logic [31:0] word,
                                        input logic [31:0] mask,
                                        input logic [31:0] pat);
    return (word & mask) == pat;
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of one instruction word: branch class, halt, branch target and
// the not-taken-view alternate PC (pc+4 for B/BL/other, the target for conditional branches).
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  logic [INSN_W-1:0] insn,
  input  logic [GPR_W-1:0]  pc,
  output logic              is_uncond,
  output logic              is_cond,
  output logic              is_halt,
  output logic [GPR_W-1:0]  target,
  output logic [GPR_W-1:0]  branch_PC
);

  logic [GPR_W-1:0] disp26;
  logic [GPR_W-1:0] disp19;
  logic [GPR_W-1:0] pc_plus4;

  assign disp26   = {{(GPR_W-28){insn[25]}}, insn[25:0], 2'b00};
  assign disp19   = {{(GPR_W-21){insn[23]}}, insn[23:5], 2'b00};
  assign pc_plus4 = pc + GPR_W'(4);

  always_comb begin
    is_uncond = insn_matches(insn, B_MASK, B_PAT) || insn_matches(insn, B_MASK, BL_PAT);
    is_cond   = insn_matches(insn, BCOND_MASK, BCOND_PAT) ||
                insn_matches(insn, CB_MASK, CBZ_PAT) ||
                insn_matches(insn, CB_MASK, CBNZ_PAT);
    is_halt   = insn_matches(insn, HLT_MASK, HLT_PAT);
    target    = pc_plus4;
    if (is_uncond) begin
      target = pc + disp26;
    end else if (is_cond) begin
      target = pc + disp19;
    end
    branch_PC = is_cond ? target : pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, 1-cycle imem read, 1-entry skid, static B/BL prediction, HLT.
// Build option FETCH_BTFN_PREDICT_EN predicts backward conditional branches taken.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          INSN_WIDTH = INSN_W,
  parameter int          PC_WIDTH   = GPR_W
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_stall,
  input  logic                  in_redirect_valid,
  input  logic [PC_WIDTH-1:0]   in_redirect_pc,
  output logic                  out_imem_req,
  output logic [PC_WIDTH-1:0]   out_imem_addr,
  input  logic [INSN_WIDTH-1:0] in_imem_rdata,
  output logic                  out_reg_done,
  output logic [INSN_WIDTH-1:0] out_reg_insnbits,
  output logic [PC_WIDTH-1:0]   out_reg_pc,
  output logic [PC_WIDTH-1:0]   out_reg_branch_PC,
  output logic                  out_reg_halted
);

  // Dispatch handshake: out_reg_done is a one-cycle valid with no ready of its own;
  // in_stall acts as the inverse ready. While in_stall is high nothing is emitted, no new
  // request is made, and a response that lands is parked in the skid register.

  fetch_state_t state;

  logic [PC_WIDTH-1:0]   fetch_pc;

  logic                  inf_valid;
  logic                  inf_squash;
  logic [PC_WIDTH-1:0]   inf_pc;

  logic                  skid_valid;
  logic [INSN_WIDTH-1:0] skid_insn;
  logic [PC_WIDTH-1:0]   skid_pc;

  logic                  resp_live;
  logic                  emit_valid;
  logic [INSN_WIDTH-1:0] emit_insn;
  logic [PC_WIDTH-1:0]   emit_pc;

  logic                  pd_uncond;
  logic                  pd_cond;
  logic                  pd_halt;
  logic                  pd_taken;
  logic [PC_WIDTH-1:0]   pd_target;
  logic [PC_WIDTH-1:0]   pd_branch_pc;
  logic [PC_WIDTH-1:0]   emit_branch_pc;

  assign out_imem_req  = (state == FETCH_RUN) && !in_stall;
  assign out_imem_addr = fetch_pc;

  // The skid entry is always older than any live response, so it goes first.
  assign resp_live  = inf_valid && !inf_squash;
  assign emit_valid = skid_valid || resp_live;
  assign emit_insn  = skid_valid ? skid_insn : in_imem_rdata;
  assign emit_pc    = skid_valid ? skid_pc : inf_pc;

  fetch_predecode u_predecode (
    .insn      (emit_insn),
    .pc        (emit_pc),
    .is_uncond (pd_uncond),
    .is_cond   (pd_cond),
    .is_halt   (pd_halt),
    .target    (pd_target),
    .branch_PC (pd_branch_pc)
  );

`ifdef FETCH_BTFN_PREDICT_EN
  // Backward conditional branches (sign bit of imm19 set) are redirected like B.
  assign pd_taken = pd_uncond || (pd_cond && emit_insn[23]);
`else
  logic unused_pd_cond;
  assign unused_pd_cond = pd_cond;
  assign pd_taken       = pd_uncond;
`endif

  // A predicted-taken branch reports its fall-through as the alternate path.
  assign emit_branch_pc = pd_taken ? (emit_pc + PC_WIDTH'(4)) : pd_branch_pc;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state             <= FETCH_RUN;
      fetch_pc          <= RESET_PC;
      inf_valid         <= 1'b0;
      inf_squash        <= 1'b0;
      inf_pc            <= '0;
      skid_valid        <= 1'b0;
      skid_insn         <= '0;
      skid_pc           <= '0;
      out_reg_done      <= 1'b0;
      out_reg_insnbits  <= '0;
      out_reg_pc        <= '0;
      out_reg_branch_PC <= '0;
      out_reg_halted    <= 1'b0;
    end else if (in_redirect_valid) begin
      state          <= FETCH_RUN;
      fetch_pc       <= in_redirect_pc;
      inf_valid      <= 1'b0;
      inf_squash     <= 1'b0;
      skid_valid     <= 1'b0;
      out_reg_done   <= 1'b0;
      out_reg_halted <= 1'b0;
    end else if (state == FETCH_HALTED) begin
      inf_valid    <= 1'b0;
      skid_valid   <= 1'b0;
      out_reg_done <= 1'b0;
    end else if (in_stall) begin
      // No request goes out while stalled, so at most one response needs parking.
      inf_valid    <= 1'b0;
      out_reg_done <= 1'b0;
      if (resp_live) begin
        skid_valid <= 1'b1;
        skid_insn  <= in_imem_rdata;
        skid_pc    <= inf_pc;
      end
    end else begin
      out_reg_done <= emit_valid;
      if (emit_valid) begin
        out_reg_insnbits  <= emit_insn;
        out_reg_pc        <= emit_pc;
        out_reg_branch_PC <= emit_branch_pc;
      end
      skid_valid <= 1'b0;
      inf_valid  <= 1'b1;
      inf_pc     <= fetch_pc;
      // The request made alongside a taken branch or HLT is on the wrong path.
      inf_squash <= emit_valid && (pd_taken || pd_halt);
      if (emit_valid && pd_taken) begin
        fetch_pc <= pd_target;
      end else begin
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end
      if (emit_valid && pd_halt) begin
        state          <= FETCH_HALTED;
        out_reg_halted <= 1'b1;
      end
    end
  end

endmodule
